alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: single-issue ALU with a valid/ready request port and a
// registered valid/ready result port. Arithmetic and logic ops finish in
// one cycle. Shifts and rotates move one bit per cycle in the SHIFT state.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [4:0]       flags
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        SH_LEFT,
        SH_RIGHT,
        SH_ROTL
    } shkind_t;

    state_t           state_q,     state_d;
    shkind_t          kind_q,      kind_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q,         y_d;
    logic [4:0]       flags_q,     flags_d;
    logic [CNTW-1:0]  cnt_q,       cnt_d;
    logic [WIDTH-1:0] work_q,      work_d;

    logic             accept;
    logic             is_shift;
    logic [CNTW-1:0]  acc_cnt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] imm_y;
    logic             imm_c;
    logic             imm_v;
    logic             imm_err;
    logic [4:0]       imm_flags;
    logic [WIDTH-1:0] step_y;
    logic             step_c;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_shift  = (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign flags     = flags_q;

    // Shift count reduced modulo WIDTH so non-power-of-two widths wrap correctly
    always_comb begin
        acc_cnt = CNTW'(32'(b[CNTW-1:0]) % WIDTH);
    end

    // Single-cycle result: ops 0-7, 11, illegal ops, and shifts by zero
    always_comb begin
        sum     = '0;
        imm_y   = '0;
        imm_c   = 1'b0;
        imm_v   = 1'b0;
        imm_err = 1'b0;
        case (op)
            4'd0: begin
                sum   = {1'b0, a} + {{WIDTH{1'b0}}, carry_in};
                imm_y = sum[WIDTH-1:0];
                imm_c = sum[WIDTH];
            end
            4'd1: begin
                sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
                imm_y = sum[WIDTH-1:0];
                imm_c = sum[WIDTH];
                imm_v = (a[WIDTH-1] == b[WIDTH-1]) && (imm_y[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, carry_in};
                imm_y = sum[WIDTH-1:0];
                imm_c = sum[WIDTH];
                imm_v = (a[WIDTH-1] != b[WIDTH-1]) && (imm_y[WIDTH-1] != a[WIDTH-1]);
            end
            4'd3: begin
                // a-1 as a + all-ones, so carry-out is set for every a except zero
                sum   = {1'b0, a} + {1'b0, {WIDTH{1'b1}}};
                imm_y = sum[WIDTH-1:0];
                imm_c = sum[WIDTH];
            end
            4'd4:                imm_y = a & b;
            4'd5:                imm_y = a | b;
            4'd6:                imm_y = a ^ b;
            4'd7:                imm_y = ~a;
            4'd8, 4'd9, 4'd10:   imm_y = a;
            4'd11:               imm_y = '0;
            default:             imm_err = 1'b1;
        endcase
        imm_flags = {imm_err, imm_v, imm_y[WIDTH-1], ~|imm_y, imm_c};
    end

    // One-bit shift step applied to the working register while in SHIFT
    always_comb begin
        step_y = work_q;
        step_c = 1'b0;
        case (kind_q)
            SH_LEFT: begin
                step_y = {work_q[WIDTH-2:0], 1'b0};
                step_c = work_q[WIDTH-1];
            end
            SH_RIGHT: begin
                step_y = {1'b0, work_q[WIDTH-1:1]};
                step_c = work_q[0];
            end
            default: begin
                step_y = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                step_c = 1'b0;
            end
        endcase
    end

    // Next-state: control FSM, shift datapath and result register
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        flags_d     = flags_q;
        cnt_d       = cnt_q;
        work_d      = work_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (acc_cnt != '0)) begin
                        state_d = SHIFT;
                        work_d  = a;
                        cnt_d   = acc_cnt;
                        if (op == 4'd8) begin
                            kind_d = SH_LEFT;
                        end else if (op == 4'd9) begin
                            kind_d = SH_RIGHT;
                        end else begin
                            kind_d = SH_ROTL;
                        end
                    end else begin
                        y_d         = imm_y;
                        flags_d     = imm_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d = step_y;
                cnt_d  = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d     = IDLE;
                    y_d         = step_y;
                    flags_d     = {1'b0, 1'b0, step_y[WIDTH-1], ~|step_y, step_c};
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kind_q      <= SH_LEFT;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            flags_q     <= '0;
            cnt_q       <= '0;
            work_q      <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 with an arithmetic reference model.
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic       carry_in;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [4:0] flags;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .carry_in  (carry_in),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sgn8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Reference: expected y, flags {err,v,n,z,c} and latency in cycles
    function automatic void model(input int o, input int c, input int aa, input int bb,
                                  output int ey, output int ef, output int el);
        int k, s, ss, cf, v, err;
        k = bb % 8; cf = 0; v = 0; err = 0; ey = 0;
        case (o)
            0: begin s = aa + c; ey = s % 256; cf = (s > 255) ? 1 : 0; end
            1: begin
                s = aa + bb + c; ey = s % 256; cf = (s > 255) ? 1 : 0;
                ss = sgn8(aa) + sgn8(bb) + c; v = (ss > 127 || ss < -128) ? 1 : 0;
            end
            2: begin
                s = aa + (255 - bb) + c; ey = s % 256; cf = (s > 255) ? 1 : 0;
                ss = sgn8(aa) - sgn8(bb) - 1 + c; v = (ss > 127 || ss < -128) ? 1 : 0;
            end
            3: begin ey = (aa + 255) % 256; cf = (aa != 0) ? 1 : 0; end
            4: ey = aa & bb;
            5: ey = aa | bb;
            6: ey = aa ^ bb;
            7: ey = 255 - aa;
            8: begin ey = (aa << k) % 256; cf = (k != 0) ? (aa >> (8 - k)) % 2 : 0; end
            9: begin ey = aa >> k; cf = (k != 0) ? (aa >> (k - 1)) % 2 : 0; end
            10: ey = (k == 0) ? aa : ((aa << k) | (aa >> (8 - k))) % 256;
            11: ey = 0;
            default: begin ey = 0; err = 1; end
        endcase
        ef = err * 16 + v * 8 + (ey / 128) * 4 + ((ey == 0) ? 2 : 0) + cf;
        el = (o >= 8 && o <= 10) ? 1 + k : 1;
    endfunction

    // Drive one request, wait for its result; returns result and latency
    task automatic run_op(input int o, input int c, input int aa, input int bb,
                          output int ry, output int rf, output int lat);
        int g;
        @(negedge clk);
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            bad++;
            $display("FAIL run_op_ready_timeout in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b1; op = 4'(o); carry_in = c[0]; a = 8'(aa); b = 8'(bb);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
        ry = int'(y);
        rf = int'(flags);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; carry_in = 1'b0; a = '0; b = '0;
        #12;
        total++;
        if (out_valid !== 1'b0 || y !== 8'h00 || flags !== 5'h00) begin
            bad++;
            $display("FAIL reset_state out_valid=%0b y=%h flags=%b required 0/00/00000",
                     out_valid, y, flags);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%0b required=1", in_ready);
        end
    endtask

    task automatic test_add;
        int ry, rf, lat;
        run_op(1, 0, 8'h7F, 8'h01, ry, rf, lat);
        total++;
        if (ry !== 8'h80 || rf !== 5'b01100 || lat !== 1) begin
            bad++;
            $display("FAIL add_overflow y=%h flags=%b lat=%0d required 80/01100/1", ry, rf, lat);
        end
    endtask

    task automatic test_sub;
        int ry, rf, lat;
        run_op(2, 1, 8'h05, 8'h05, ry, rf, lat);
        total++;
        if (ry !== 8'h00 || rf !== 5'b00011 || lat !== 1) begin
            bad++;
            $display("FAIL sub_equal y=%h flags=%b lat=%0d required 00/00011/1", ry, rf, lat);
        end
        run_op(3, 0, 8'h00, 8'h00, ry, rf, lat);
        total++;
        if (ry !== 8'hFF || rf !== 5'b00100) begin
            bad++;
            $display("FAIL dec_zero y=%h flags=%b required ff/00100", ry, rf);
        end
    endtask

    task automatic test_shift;
        int ry, rf, lat;
        @(negedge clk);
        in_valid = 1'b1; op = 4'd8; carry_in = 1'b0; a = 8'h81; b = 8'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL shift_busy cycle=%0d in_ready=%0b out_valid=%0b required 0/0",
                         i, in_ready, out_valid);
            end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || y !== 8'h08 || flags !== 5'b00000) begin
            bad++;
            $display("FAIL shift_left_result out_valid=%0b y=%h flags=%b required 1/08/00000",
                     out_valid, y, flags);
        end
        run_op(10, 0, 8'h81, 8'd1, ry, rf, lat);
        total++;
        if (ry !== 8'h03 || lat !== 2) begin
            bad++;
            $display("FAIL rotate_left y=%h lat=%0d required 03/2", ry, lat);
        end
    endtask

    task automatic test_illegal;
        int ry, rf, lat;
        run_op(13, 1, 8'hAA, 8'h55, ry, rf, lat);
        total++;
        if (ry !== 8'h00 || rf !== 5'b10010 || lat !== 1) begin
            bad++;
            $display("FAIL illegal_op y=%h flags=%b lat=%0d required 00/10010/1", ry, rf, lat);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd1; carry_in = 1'b0; a = 8'h03; b = 8'h04;
        @(posedge clk);
        #1 op = 4'd5; a = 8'hF0; b = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || y !== 8'h07 || flags !== 5'b00000 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d ov=%0b y=%h flags=%b in_ready=%0b required 1/07/00000/0",
                         i, out_valid, y, flags, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || y !== 8'hFF || flags !== 5'b00100) begin
            bad++;
            $display("FAIL bp_release ov=%0b y=%h flags=%b required 1/ff/00100", out_valid, y, flags);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_single_result out_valid=%0b required=0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int ey, ef, el, po, pa, pb, pc;
        @(negedge clk);
        po = $urandom_range(7, 0); pa = $urandom_range(255, 0);
        pb = $urandom_range(255, 0); pc = $urandom_range(1, 0);
        in_valid = 1'b1; op = 4'(po); a = 8'(pa); b = 8'(pb); carry_in = pc[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            model(po, pc, pa, pb, ey, ef, el);
            total++;
            if (out_valid !== 1'b1 || int'(y) !== ey || int'(flags) !== ef) begin
                bad++;
                $display("FAIL b2b idx=%0d op=%0d ov=%0b y=%h flags=%b required 1/%h/%b",
                         i, po, out_valid, y, flags, 8'(ey), 5'(ef));
            end
            po = $urandom_range(7, 0); pa = $urandom_range(255, 0);
            pb = $urandom_range(255, 0); pc = $urandom_range(1, 0);
            op = 4'(po); a = 8'(pa); b = 8'(pb); carry_in = pc[0];
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        int o, c, aa, bb, ry, rf, lat, ey, ef, el;
        for (int i = 0; i < 60; i++) begin
            o = $urandom_range(15, 0); c = $urandom_range(1, 0);
            aa = $urandom_range(255, 0); bb = $urandom_range(255, 0);
            model(o, c, aa, bb, ey, ef, el);
            run_op(o, c, aa, bb, ry, rf, lat);
            total++;
            if (ry !== ey || rf !== ef || lat !== el) begin
                bad++;
                $display("FAIL random op=%0d a=%h b=%h cin=%0d y=%h flags=%b lat=%0d required %h/%b/%0d",
                         o, 8'(aa), 8'(bb), c, 8'(ry), 5'(rf), lat, 8'(ey), 5'(ef), el);
            end
        end
    endtask

    task automatic test_reset_mid_shift;
        int ry, rf, lat, seen;
        run_op(4, 0, 8'hF0, 8'h3C, ry, rf, lat);
        @(negedge clk);
        in_valid = 1'b1; op = 4'd9; carry_in = 1'b0; a = 8'hC5; b = 8'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || y !== 8'h30) begin
            bad++;
            $display("FAIL mid_shift_busy in_ready=%0b ov=%0b y=%h required 0/0/30", in_ready, out_valid, y);
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || y !== 8'h00 || flags !== 5'h00) begin
            bad++;
            $display("FAIL async_reset ov=%0b y=%h flags=%b required 0/00/00000", out_valid, y, flags);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready in_ready=%0b required=1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL discarded_shift result_cycles=%0d required=0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
